// File: rtl/digit_scroller_pkg.sv
// digit_scroller_pkg: display constants, FSM state type and the digit-to-bit-slice
// mapping that both the scroller and the TM1638 driver use.
package digit_scroller_pkg;

   localparam int DIGITS  = 8;
   localparam int DIGIT_W = 4;
   localparam int SEG_W   = DIGITS * DIGIT_W;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Lowest bit of window digit k on the digit bus; digit 0 is leftmost.
   function automatic int seg_lsb(input int k);
      return k * DIGIT_W;
   endfunction

endpackage

// File: rtl/digit_scroller_tick.sv
// tick_prescaler: counts enabled cycles 0..TICK_DIV-1 and pulses tick on the
// terminal count. clear restarts the count from zero and masks tick.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = enable && !clear && (count == TERM);

   // Cycle counter; holds its value while enable is low.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/digit_scroller.sv
// digit_scroller: programmable hex-digit marquee feeding the TM1638 driver.
// Shows an 8-digit window of a message held in a small memory, advancing one
// digit per prescaler tick. Define DIGIT_SCROLLER_BOUNCE_EN for ping-pong
// scrolling; the default build wraps the head modulo the message length.
module digit_scroller
   import digit_scroller_pkg::*;
#(
   parameter  int MSG_LEN  = 16,
   parameter  int TICK_DIV = 50_000_000,
   localparam int AW       = $clog2(MSG_LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [3:0]       wr_data,
   input  logic [AW:0]      len,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             dir,
   output logic [SEG_W-1:0] seg_out,
   output logic             step_pulse,
   output logic             busy
);

   localparam logic [AW:0] MSG_LEN_V = (AW+1)'(MSG_LEN);
   localparam logic [AW:0] ONE_L     = (AW+1)'(1);

   state_t               state, state_next;
   logic [DIGIT_W-1:0]   mem [MSG_LEN];
   logic [AW-1:0]        head, head_step, load_head;
   logic [AW:0]          msg_len, len_clamp, load_len, head_p1, idx;
   logic [SEG_W-1:0]     win;
   logic                 start_ok, load, tick;
`ifdef DIGIT_SCROLLER_BOUNCE_EN
   logic                 bounce_dn, bounce_dn_next, up;
   logic [AW:0]          limit;
`endif

   // stop always beats start; a zero length start is ignored.
   assign len_clamp = (len > MSG_LEN_V) ? MSG_LEN_V : len;
   assign start_ok  = start && !stop && (len != '0);
   assign head_p1   = {1'b0, head} + ONE_L;
   assign busy      = (state == RUN);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start_ok || stop),
      .enable ((state == RUN) && !hold),
      .tick   (tick)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and window-load decision; tick only fires while in RUN.
   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      load       = 1'b0;
      if (stop) begin
         state_next = IDLE;
      end else if (start_ok) begin
         state_next = RUN;
         load       = 1'b1;
      end else if (tick) begin
         load = 1'b1;
      end
   end

   // Head position after one scroll step.
   always_comb begin
`ifdef DIGIT_SCROLLER_BOUNCE_EN
      limit          = msg_len - (AW+1)'(DIGITS);
      up             = 1'b0;
      head_step      = '0;
      bounce_dn_next = bounce_dn;
      if (msg_len > (AW+1)'(DIGITS)) begin
         up             = bounce_dn ? (head == '0) : (head_p1 <= limit);
         head_step      = up ? head_p1[AW-1:0] : head - AW'(1);
         bounce_dn_next = up ? (head_p1 == limit) : (head != AW'(1));
      end
`else
      if (dir) head_step = (head == '0) ? AW'(msg_len - ONE_L) : head - AW'(1);
      else     head_step = (head_p1 == msg_len) ? '0 : head_p1[AW-1:0];
`endif
   end

   // Window contents for the next load; a same-cycle write is forwarded.
   always_comb begin
      load_len  = start_ok ? len_clamp : msg_len;
      load_head = start_ok ? '0 : head_step;
      idx       = {1'b0, load_head};
      win       = '0;
      for (int k = 0; k < DIGITS; k++) begin
         win[seg_lsb(k) +: DIGIT_W] = (wr_en && (wr_addr == idx[AW-1:0])) ? wr_data
                                                                          : mem[idx[AW-1:0]];
         idx = idx + ONE_L;
         if (idx >= load_len) idx = '0;
      end
   end

   // Message memory, writable in any state.
   // NOTE: the memory is reset explicitly because a reset must clear the message.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MSG_LEN; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Head, latched length, displayed window and step strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         msg_len    <= '0;
         seg_out    <= '0;
         step_pulse <= 1'b0;
`ifdef DIGIT_SCROLLER_BOUNCE_EN
         bounce_dn  <= 1'b0;
`endif
      end else begin
         step_pulse <= load;
         if (load) seg_out <= win;
         if (start_ok) begin
            msg_len   <= len_clamp;
            head      <= '0;
`ifdef DIGIT_SCROLLER_BOUNCE_EN
            bounce_dn <= dir;
`endif
         end else if (load) begin
            head      <= head_step;
`ifdef DIGIT_SCROLLER_BOUNCE_EN
            bounce_dn <= bounce_dn_next;
`endif
         end
      end
   end

endmodule

// File: tb/tb_digit_scroller.sv
// tb_digit_scroller: directed bench with a scoreboard of expected windows.
// Expected windows are pushed when the stimulus that causes a load is driven
// and popped when step_pulse is seen.
module tb_digit_scroller;

   localparam int MSG_LEN  = 16;
   localparam int TICK_DIV = 4;
   localparam int AW       = 4;

   logic          clk = 1'b0;
   logic          rst_n, wr_en, start, stop, hold, dir;
   logic [AW-1:0] wr_addr;
   logic [3:0]    wr_data;
   logic [AW:0]   len;
   logic [31:0]   seg_out;
   logic          step_pulse, busy;

   int            checks = 0;
   int            failures = 0;
   logic [3:0]    m [MSG_LEN];
   int            mh, ml;
   logic          mbdir;
   logic [31:0]   exp_q [$];
   logic [31:0]   last_win;
   int            n, pulses, changes;

   digit_scroller #(.MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .start(start), .stop(stop), .hold(hold), .dir(dir),
      .seg_out(seg_out), .step_pulse(step_pulse), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_win(input int h, input int l);
      logic [31:0] w = '0;
      for (int k = 0; k < 8; k++) w[4*k +: 4] = m[(h + k) % l];
      return w;
   endfunction

   function automatic void model_step();
`ifdef DIGIT_SCROLLER_BOUNCE_EN
      int lim;
      if (ml > 8) begin
         lim = ml - 8;
         if (!mbdir && mh == lim) mbdir = 1'b1;
         else if (mbdir && mh == 0) mbdir = 1'b0;
         mh = mbdir ? mh - 1 : mh + 1;
         if (mh == lim) mbdir = 1'b1;
         if (mh == 0)   mbdir = 1'b0;
      end
`else
      mh = dir ? (mh + ml - 1) % ml : (mh + 1) % ml;
`endif
   endfunction

   task automatic write_mem(input int a, input logic [3:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      m[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic do_start(input int l);
      start = 1'b1; len = (AW+1)'(l);
      if (l != 0) begin
         ml = (l > MSG_LEN) ? MSG_LEN : l; mh = 0; mbdir = dir;
         exp_q.push_back(exp_win(0, ml));
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_step(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!step_pulse && cnt < 100);
      if (!step_pulse) check("step_timeout", {31'd0, step_pulse}, 32'd1);
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check(tag, seg_out, e);
      last_win = seg_out;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
      start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0;
      for (int i = 0; i < MSG_LEN; i++) m[i] = '0;
      mh = 0; ml = 0; mbdir = 1'b0; last_win = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_seg", seg_out, 32'h0);
      check("reset_pulse", {31'd0, step_pulse}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);

      // Load message 0..F and scroll a full lap.
      for (int i = 0; i < MSG_LEN; i++) write_mem(i, 4'(i));
      do_start(16);
      check("start_pulse", {31'd0, step_pulse}, 32'd1);
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_const", seg_out, 32'h7654_3210);
      pop_check("start_win");
      for (int s = 1; s <= 15; s++) begin
         model_step();
         exp_q.push_back(exp_win(mh, ml));
         wait_step(n);
         check("step_gap", n, TICK_DIV);
         pop_check("step_win");
         if (s == 1) check("step1_const", seg_out, 32'h8765_4321);
      end
`ifndef DIGIT_SCROLLER_BOUNCE_EN
      check("wrap_const", seg_out, 32'h6543_210F);
`endif

      // Restart from RUN with a short message, then one right step.
      do_start(3);
      check("len3_pulse", {31'd0, step_pulse}, 32'd1);
      check("len3_const", seg_out, 32'h1021_0210);
      pop_check("len3_win");
      dir = 1'b1;
      model_step();
      exp_q.push_back(exp_win(mh, ml));
      wait_step(n);
      check("right_gap", n, TICK_DIV);
      pop_check("right_win");
`ifndef DIGIT_SCROLLER_BOUNCE_EN
      check("right_const", seg_out, 32'h0210_2102);
`endif
      dir = 1'b0;

      // Hold for 10 cycles mid-count.
      model_step();
      exp_q.push_back(exp_win(mh, ml));
      @(negedge clk);
      hold = 1'b1;
      repeat (10) @(negedge clk);
      hold = 1'b0;
      wait_step(n);
      check("hold_gap", n + 11, TICK_DIV + 10);
      pop_check("hold_win");

      // Stop freezes the display.
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_busy", {31'd0, busy}, 32'd0);
      check("stop_pulse", {31'd0, step_pulse}, 32'd0);
      pulses = 0; changes = 0;
      repeat (20) begin
         @(negedge clk);
         if (step_pulse) pulses++;
         if (seg_out !== last_win) changes++;
      end
      check("frozen_pulses", pulses, 0);
      check("frozen_changes", changes, 0);

      // start+stop together from RUN, then a zero-length start.
      do_start(16);
      pop_check("run_again_win");
      start = 1'b1; stop = 1'b1; len = 5'd5;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("startstop_busy", {31'd0, busy}, 32'd0);
      check("startstop_pulse", {31'd0, step_pulse}, 32'd0);
      check("startstop_seg", seg_out, last_win);
      do_start(0);
      check("len0_busy", {31'd0, busy}, 32'd0);
      check("len0_pulse", {31'd0, step_pulse}, 32'd0);
      repeat (6) @(negedge clk);
      check("len0_seg", seg_out, last_win);
      check("len0_idle", {31'd0, busy}, 32'd0);

      // Write while displayed: visible only at the next step.
      do_start(16);
      pop_check("wr_start_win");
      write_mem(3, 4'hA);
      check("wr_no_refresh", seg_out, last_win);
      model_step();
      exp_q.push_back(exp_win(mh, ml));
      wait_step(n);
      check("wr_gap", n, TICK_DIV - 1);
      pop_check("wr_step_win");
      check("wr_const", seg_out, 32'h8765_4A21);

      // Write lands in the same cycle as a step: forwarded into the window.
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'hC; m[5] = 4'hC;
      model_step();
      exp_q.push_back(exp_win(mh, ml));
      @(negedge clk);
      wr_en = 1'b0;
      check("fwd_pulse", {31'd0, step_pulse}, 32'd1);
      pop_check("fwd_win");

`ifdef DIGIT_SCROLLER_BOUNCE_EN
      // Ping-pong over a 10-digit message: heads 0,1,2,1,0,1.
      begin
         int hl [6] = '{0, 1, 2, 1, 0, 1};
         do_start(10);
         check("bounce_h0", seg_out, exp_win(hl[0], 10));
         pop_check("bounce_start");
         for (int j = 1; j < 6; j++) begin
            model_step();
            exp_q.push_back(exp_win(mh, ml));
            wait_step(n);
            check("bounce_head", seg_out, exp_win(hl[j], 10));
            pop_check("bounce_win");
         end
      end
`endif

      // Asynchronous reset mid-run clears outputs and the message.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_seg", seg_out, 32'h0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_pulse", {31'd0, step_pulse}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < MSG_LEN; i++) m[i] = '0;
      exp_q.delete();
      write_mem(7, 4'h9);
      do_start(16);
      check("arst_mem_pulse", {31'd0, step_pulse}, 32'd1);
      pop_check("arst_mem_win");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
